// File: rtl/qspi_rx_packer_pkg.sv
// Shared encodings for the QSPI receive path: lane modes, packer FSM states
// and the per-lane samples-per-byte lookup.
package qspi_rx_packer_pkg;

  typedef enum logic [1:0] {
    LANE_X1 = 2'b00,
    LANE_X2 = 2'b01,
    LANE_X4 = 2'b10
  } lane_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RECV  = 2'b01,
    ST_DRAIN = 2'b10
  } state_e;

  localparam int REMAIN_W = 16;

  // 2'b11 is treated as x4, so the top bit alone selects quad mode.
  function automatic lane_e decode_lanes(input logic [1:0] lanes);
    if (lanes[1])      return LANE_X4;
    else if (lanes[0]) return LANE_X2;
    else               return LANE_X1;
  endfunction

  function automatic logic [2:0] last_sample_idx(input lane_e lanes);
    case (lanes)
      LANE_X1: return 3'd7;
      LANE_X2: return 3'd3;
      default: return 3'd1;
    endcase
  endfunction

endpackage

// File: rtl/qspi_rx_packer.sv
// Packs QSPI receive samples (x1/x2/x4, MSB-first per byte) into little-endian
// 32-bit words and hands them to fifo_rx through a one-entry pending register.
module qspi_rx_packer
  import qspi_rx_packer_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic [1:0]       lanes_i,
  input  logic [15:0]      len_i,
  input  logic             sample_i,
  input  logic [3:0]       io_i,
  input  logic             fifo_full_i,
  output logic             fifo_wr_en_o,
  output logic [WIDTH-1:0] fifo_wr_data_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             stall_o,
  output logic             overflow_o
);

  state_e                r_state;
  state_e                w_state_nxt;
  lane_e                 r_lanes;
  logic [REMAIN_W-1:0]   r_remain;
  logic [7:0]            r_shift;
  logic [2:0]            r_samp_cnt;
  logic [1:0]            r_byte_idx;
  logic [WIDTH-1:0]      r_word;
  logic [WIDTH-1:0]      r_pend_data;
  logic                  r_pend;
  logic                  r_overflow;
  logic                  r_done;

  logic                  w_start;
  logic                  w_take;
  logic [7:0]            w_byte_nxt;
  logic                  w_byte_done;
  logic                  w_last_byte;
  logic                  w_word_done;
  logic [WIDTH-1:0]      w_word_val;
  logic                  w_wr_en;
  logic                  w_busy;
  logic                  w_finish;

  assign w_start     = start_i && (r_state == ST_IDLE);
  assign w_take      = sample_i && (r_state == ST_RECV) && (r_remain != '0);
  assign w_byte_done = w_take && (r_samp_cnt == last_sample_idx(r_lanes));
  assign w_last_byte = (r_remain == 16'd1);
  assign w_word_done = w_byte_done && ((r_byte_idx == 2'd3) || w_last_byte);
  assign w_word_val  = r_word | ({{(WIDTH-8){1'b0}}, w_byte_nxt} << {r_byte_idx, 3'b000});
  assign w_wr_en     = r_pend && !fifo_full_i;

  always_comb begin
    case (r_lanes)
      LANE_X1: w_byte_nxt = {r_shift[6:0], io_i[1]};
      LANE_X2: w_byte_nxt = {r_shift[5:0], io_i[1:0]};
      default: w_byte_nxt = {r_shift[3:0], io_i};
    endcase
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // FSM: next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_start) w_state_nxt = (len_i == '0) ? ST_DRAIN : ST_RECV;
      end
      ST_RECV: begin
        if (w_byte_done && w_last_byte) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!r_pend || w_wr_en) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM: outputs; leaving DRAIN is taken once the pending word is gone after this edge
  always_comb begin
    w_busy   = (r_state != ST_IDLE);
    w_finish = (r_state == ST_DRAIN) && (!r_pend || w_wr_en);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_lanes     <= LANE_X1;
      r_remain    <= '0;
      r_shift     <= '0;
      r_samp_cnt  <= '0;
      r_byte_idx  <= '0;
      r_word      <= '0;
      r_pend      <= 1'b0;
      r_pend_data <= '0;
      r_overflow  <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= w_finish;
      if (w_start) begin
        r_lanes    <= decode_lanes(lanes_i);
        r_remain   <= len_i;
        r_shift    <= '0;
        r_samp_cnt <= '0;
        r_byte_idx <= '0;
        r_word     <= '0;
        r_overflow <= 1'b0;
      end else if (w_take) begin
        if (w_byte_done) begin
          r_shift    <= '0;
          r_samp_cnt <= '0;
          r_remain   <= r_remain - 16'd1;
          if (w_word_done) begin
            r_word     <= '0;
            r_byte_idx <= '0;
          end else begin
            r_word     <= w_word_val;
            r_byte_idx <= r_byte_idx + 2'd1;
          end
        end else begin
          r_shift    <= w_byte_nxt;
          r_samp_cnt <= r_samp_cnt + 3'd1;
        end
      end

      // A word landing while the previous one is still stuck is lost.
      if (w_word_done && (!r_pend || w_wr_en)) begin
        r_pend      <= 1'b1;
        r_pend_data <= w_word_val;
      end else if (w_wr_en) begin
        r_pend <= 1'b0;
      end
      if (w_word_done && r_pend && !w_wr_en) r_overflow <= 1'b1;
    end
  end

  assign fifo_wr_en_o   = w_wr_en;
  assign fifo_wr_data_o = r_pend ? r_pend_data : '0;
  assign stall_o        = r_pend && fifo_full_i;
  assign busy_o         = w_busy;
  assign done_o         = r_done;
  assign overflow_o     = r_overflow;

endmodule

// File: tb/tb_qspi_rx_packer.sv
// Self-checking bench for qspi_rx_packer: directed vectors plus randomized
// transfers compared against a byte/word level reference model.
module tb_qspi_rx_packer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_i;
  logic [1:0]  lanes_i;
  logic [15:0] len_i;
  logic        sample_i;
  logic [3:0]  io_i;
  logic        fifo_full_i;
  logic        fifo_wr_en_o;
  logic [31:0] fifo_wr_data_o;
  logic        busy_o;
  logic        done_o;
  logic        stall_o;
  logic        overflow_o;

  int total = 0;
  int bad   = 0;

  logic [31:0] got_q[$];
  logic [31:0] exp_q[$];
  logic [7:0]  bytes_q[$];
  logic [3:0]  samp_q[$];
  int          done_cnt = 0;

  always #5 clk = ~clk;

  qspi_rx_packer #(.WIDTH(32)) dut (
    .clk            (clk),
    .reset          (reset),
    .start_i        (start_i),
    .lanes_i        (lanes_i),
    .len_i          (len_i),
    .sample_i       (sample_i),
    .io_i           (io_i),
    .fifo_full_i    (fifo_full_i),
    .fifo_wr_en_o   (fifo_wr_en_o),
    .fifo_wr_data_o (fifo_wr_data_o),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .stall_o        (stall_o),
    .overflow_o     (overflow_o)
  );

  always @(negedge clk) begin
    if (fifo_wr_en_o) got_q.push_back(fifo_wr_data_o);
    if (done_o) done_cnt++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    start_i     = 1'b0;
    lanes_i     = 2'b00;
    len_i       = 16'd0;
    sample_i    = 1'b0;
    io_i        = 4'd0;
    fifo_full_i = 1'b0;
  endtask

  // Turns one byte into lane samples, MSB first; unused IO lines carry junk.
  task automatic push_byte(input logic [1:0] ln, input logic [7:0] b);
    logic [3:0] j;
    if (ln[1]) begin
      samp_q.push_back(b[7:4]);
      samp_q.push_back(b[3:0]);
    end else if (ln[0]) begin
      for (int i = 3; i >= 0; i--) begin
        j = 4'($urandom);
        samp_q.push_back({j[3:2], b[2*i+1], b[2*i]});
      end
    end else begin
      for (int i = 7; i >= 0; i--) begin
        j = 4'($urandom);
        samp_q.push_back({j[3:2], b[i], j[0]});
      end
    end
  endtask

  // Reference: bytes grouped four at a time, little-endian, zero-filled tail.
  task automatic build_expected();
    logic [31:0] w;
    exp_q.delete();
    for (int base = 0; base < bytes_q.size(); base += 4) begin
      w = 32'd0;
      for (int k = 0; k < 4; k++)
        if (base + k < bytes_q.size()) w = w | (32'(bytes_q[base+k]) << (8 * k));
      exp_q.push_back(w);
    end
  endtask

  task automatic run_xfer(input logic [1:0] ln, input bit gaps, input bit rfull,
                          input int budget, output bit timed_out);
    bit prev_full;
    bit in_recv;
    got_q.delete();
    samp_q.delete();
    foreach (bytes_q[i]) push_byte(ln, bytes_q[i]);
    step();
    start_i = 1'b1;
    lanes_i = ln;
    len_i   = 16'(bytes_q.size());
    step();
    start_i   = 1'b0;
    prev_full = 1'b0;
    timed_out = 1'b1;
    for (int c = 0; c < budget; c++) begin
      in_recv = (samp_q.size() > 0);
      if (in_recv && (!gaps || $urandom_range(3) != 0)) begin
        sample_i = 1'b1;
        io_i     = samp_q.pop_front();
      end else begin
        sample_i = in_recv ? 1'b0 : (gaps && $urandom_range(1) == 1);
        io_i     = 4'($urandom);
      end
      start_i = gaps && in_recv && ($urandom_range(7) == 0);
      lanes_i = 2'($urandom);
      len_i   = 16'($urandom);
      if (rfull) begin
        fifo_full_i = prev_full ? 1'b0 : ($urandom_range(4) == 0);
        prev_full   = fifo_full_i;
      end
      @(negedge clk);
      if (done_o) begin
        timed_out = 1'b0;
        break;
      end
      step();
    end
    idle_inputs();
    step();
  endtask

  task automatic check_words(input string name);
    total++;
    if (got_q.size() !== exp_q.size()) begin
      bad++;
      $display("FAIL %s write count: got %0d want %0d", name, got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL %s word%0d: got %h want %h", name, i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    total += 6;
    if (busy_o !== 1'b0)          begin bad++; $display("FAIL rst busy: got %b want 0", busy_o); end
    if (done_o !== 1'b0)          begin bad++; $display("FAIL rst done: got %b want 0", done_o); end
    if (fifo_wr_en_o !== 1'b0)    begin bad++; $display("FAIL rst wr_en: got %b want 0", fifo_wr_en_o); end
    if (fifo_wr_data_o !== 32'd0) begin bad++; $display("FAIL rst data: got %h want 0", fifo_wr_data_o); end
    if (stall_o !== 1'b0)         begin bad++; $display("FAIL rst stall: got %b want 0", stall_o); end
    if (overflow_o !== 1'b0)      begin bad++; $display("FAIL rst overflow: got %b want 0", overflow_o); end
  endtask

  task automatic test_x4_vector();
    step();
    start_i = 1'b1; lanes_i = 2'b10; len_i = 16'd4;
    for (int i = 1; i <= 8; i++) begin
      step();
      start_i = 1'b0; sample_i = 1'b1; io_i = 4'(i);
    end
    step();
    sample_i = 1'b0;
    @(negedge clk);
    total += 3;
    if (fifo_wr_en_o !== 1'b1)           begin bad++; $display("FAIL x4 wr_en c9: got %b want 1", fifo_wr_en_o); end
    if (fifo_wr_data_o !== 32'h78563412) begin bad++; $display("FAIL x4 data c9: got %h want 78563412", fifo_wr_data_o); end
    if (done_o !== 1'b0)                 begin bad++; $display("FAIL x4 done c9: got %b want 0", done_o); end
    step();
    @(negedge clk);
    total += 3;
    if (done_o !== 1'b1)       begin bad++; $display("FAIL x4 done c10: got %b want 1", done_o); end
    if (busy_o !== 1'b0)       begin bad++; $display("FAIL x4 busy c10: got %b want 0", busy_o); end
    if (fifo_wr_en_o !== 1'b0) begin bad++; $display("FAIL x4 wr_en c10: got %b want 0", fifo_wr_en_o); end
    step();
    @(negedge clk);
    total++;
    if (done_o !== 1'b0) begin bad++; $display("FAIL x4 done c11: got %b want 0", done_o); end
    step();
  endtask

  task automatic test_x1();
    bit to;
    bytes_q = '{8'hA5};
    build_expected();
    run_xfer(2'b00, 1'b0, 1'b0, 200, to);
    total++;
    if (to) begin bad++; $display("FAIL x1 done: got timeout want pulse"); end
    check_words("x1");
  endtask

  task automatic test_x2();
    bit to;
    bytes_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    build_expected();
    run_xfer(2'b01, 1'b0, 1'b0, 200, to);
    total++;
    if (to) begin bad++; $display("FAIL x2 done: got timeout want pulse"); end
    check_words("x2");
  endtask

  task automatic test_overflow();
    step();
    got_q.delete();
    samp_q.delete();
    for (int k = 0; k < 12; k++) push_byte(2'b10, 8'(8'h10 + k));
    start_i = 1'b1; lanes_i = 2'b10; len_i = 16'd12; fifo_full_i = 1'b1;
    for (int c = 1; c <= 24; c++) begin
      step();
      start_i = 1'b0; sample_i = 1'b1; io_i = samp_q.pop_front();
      if (c == 9) begin
        @(negedge clk);
        total += 3;
        if (stall_o !== 1'b1)                begin bad++; $display("FAIL ovf stall: got %b want 1", stall_o); end
        if (fifo_wr_en_o !== 1'b0)           begin bad++; $display("FAIL ovf wr_en held: got %b want 0", fifo_wr_en_o); end
        if (fifo_wr_data_o !== 32'h13121110) begin bad++; $display("FAIL ovf pend data: got %h want 13121110", fifo_wr_data_o); end
      end
    end
    step();
    sample_i = 1'b0;
    @(negedge clk);
    total += 2;
    if (overflow_o !== 1'b1) begin bad++; $display("FAIL ovf flag: got %b want 1", overflow_o); end
    if (busy_o !== 1'b1)     begin bad++; $display("FAIL ovf busy: got %b want 1", busy_o); end
    step();
    fifo_full_i = 1'b0;
    @(negedge clk);
    total += 2;
    if (fifo_wr_en_o !== 1'b1)           begin bad++; $display("FAIL ovf release wr_en: got %b want 1", fifo_wr_en_o); end
    if (fifo_wr_data_o !== 32'h13121110) begin bad++; $display("FAIL ovf release data: got %h want 13121110", fifo_wr_data_o); end
    step();
    @(negedge clk);
    total += 2;
    if (done_o !== 1'b1)     begin bad++; $display("FAIL ovf done: got %b want 1", done_o); end
    if (got_q.size() !== 1)  begin bad++; $display("FAIL ovf writes: got %0d want 1", got_q.size()); end
    step();
  endtask

  task automatic test_len0();
    got_q.delete();
    step();
    start_i = 1'b1; lanes_i = 2'b00; len_i = 16'd0;
    step();
    start_i = 1'b0;
    @(negedge clk);
    total += 3;
    if (busy_o !== 1'b1)       begin bad++; $display("FAIL len0 busy: got %b want 1", busy_o); end
    if (fifo_wr_en_o !== 1'b0) begin bad++; $display("FAIL len0 wr_en: got %b want 0", fifo_wr_en_o); end
    if (overflow_o !== 1'b0)   begin bad++; $display("FAIL len0 overflow clear: got %b want 0", overflow_o); end
    step();
    @(negedge clk);
    total += 2;
    if (done_o !== 1'b1) begin bad++; $display("FAIL len0 done: got %b want 1", done_o); end
    if (busy_o !== 1'b0) begin bad++; $display("FAIL len0 busy after: got %b want 0", busy_o); end
    step();
    @(negedge clk);
    total += 2;
    if (done_o !== 1'b0)    begin bad++; $display("FAIL len0 done width: got %b want 0", done_o); end
    if (got_q.size() !== 0) begin bad++; $display("FAIL len0 writes: got %0d want 0", got_q.size()); end
    step();
  endtask

  task automatic test_reset_mid();
    int d0;
    got_q.delete();
    d0 = done_cnt;
    step();
    start_i = 1'b1; lanes_i = 2'b10; len_i = 16'd8;
    for (int i = 0; i < 3; i++) begin
      step();
      start_i = 1'b0; sample_i = 1'b1; io_i = 4'(i + 9);
    end
    step();
    sample_i = 1'b0;
    reset    = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clk);
    total += 5;
    if (busy_o !== 1'b0)          begin bad++; $display("FAIL rmid busy: got %b want 0", busy_o); end
    if (fifo_wr_en_o !== 1'b0)    begin bad++; $display("FAIL rmid wr_en: got %b want 0", fifo_wr_en_o); end
    if (fifo_wr_data_o !== 32'd0) begin bad++; $display("FAIL rmid data: got %h want 0", fifo_wr_data_o); end
    if (stall_o !== 1'b0)         begin bad++; $display("FAIL rmid stall: got %b want 0", stall_o); end
    if (done_o !== 1'b0)          begin bad++; $display("FAIL rmid done: got %b want 0", done_o); end
    for (int c = 0; c < 20; c++) begin
      step();
      sample_i = 1'b1;
      io_i     = 4'($urandom);
    end
    sample_i = 1'b0;
    step();
    total += 2;
    if (done_cnt !== d0)    begin bad++; $display("FAIL rmid later done: got %0d want %0d", done_cnt, d0); end
    if (got_q.size() !== 0) begin bad++; $display("FAIL rmid writes: got %0d want 0", got_q.size()); end
  endtask

  task automatic test_random();
    bit          to;
    logic [1:0]  ln;
    int          len;
    for (int t = 0; t < 24; t++) begin
      ln  = 2'($urandom);
      len = $urandom_range(23, 1);
      bytes_q.delete();
      for (int i = 0; i < len; i++) bytes_q.push_back(8'($urandom));
      build_expected();
      run_xfer(ln, 1'b1, 1'b1, 2000, to);
      total += 2;
      if (to) begin bad++; $display("FAIL rand%0d done: got timeout want pulse (lanes=%b len=%0d)", t, ln, len); end
      if (overflow_o !== 1'b0) begin bad++; $display("FAIL rand%0d overflow: got %b want 0", t, overflow_o); end
      check_words($sformatf("rand%0d", t));
    end
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_x4_vector();
    test_x1();
    test_x2();
    test_overflow();
    test_len0();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/qspi_rx_packer.md
QSPI_RX_PACKER -- requirements
Module: qspi_rx_packer

Interface
REQ-001 SHALL have parameter WIDTH, default 32, the FIFO word width; only 32 is supported.
REQ-002 SHALL have port clk, input, 1, the single clock; all logic is on the rising edge.
REQ-003 SHALL have port reset, input, 1, the reset; it is synchronous and active-high.
REQ-004 SHALL have port start_i, input, 1, a one-cycle pulse that begins a receive transfer.
REQ-005 SHALL have port lanes_i, input, 2, the lane mode (00 = x1, 01 = x2, 1x = x4), latched on an accepted start.
REQ-006 SHALL have port len_i, input, 16, the transfer byte count, latched on an accepted start.
REQ-007 SHALL have port sample_i, input, 1, which marks io_i as one valid IO sample this cycle.
REQ-008 SHALL have port io_i, input, 4, the sampled QSPI IO lines.
REQ-009 SHALL have port fifo_full_i, input, 1, the full flag of the downstream fifo_rx.
REQ-010 SHALL have port fifo_wr_en_o, output, 1, the write strobe to fifo_rx.
REQ-011 SHALL have port fifo_wr_data_o, output, WIDTH, the packed word.
REQ-012 SHALL have port busy_o, output, 1, high while the FSM is not in IDLE.
REQ-013 SHALL have port done_o, output, 1, a one-cycle pulse at transfer completion.
REQ-014 SHALL have port stall_o, output, 1, which asks the QSPI FSM to hold SCLK.
REQ-015 SHALL have port overflow_o, output, 1, a sticky flag for a dropped word.

Function
REQ-016 SHALL implement FSM states IDLE, RECV and DRAIN; start_i is accepted only in IDLE and is ignored otherwise.
REQ-017 On an accepted start with len_i = 0, the FSM SHALL go to DRAIN; with nonzero len_i it SHALL go to RECV; overflow_o SHALL clear.
REQ-018 The shift lanes SHALL be: x1 shifts io_i[1]; x2 shifts io_i[1:0]; x4 shifts io_i[3:0]; all MSB-first into the current byte.
REQ-019 A byte SHALL complete after 8, 4 or 2 samples for x1, x2 or x4 respectively.
REQ-020 Bytes SHALL pack little-endian: the first byte of each word goes to bits [7:0].
REQ-021 A word SHALL complete on its 4th byte, or on the final byte of the transfer; unfilled upper bytes SHALL be zero.
REQ-022 sample_i SHALL be ignored outside RECV and after the final byte has completed.
REQ-023 A completed word SHALL load a one-entry pending register on the same edge as its last sample; pending is visible from the next cycle.
REQ-024 fifo_wr_en_o SHALL equal pending && !fifo_full_i (combinational); pending SHALL clear on the edge where fifo_wr_en_o is high.
REQ-025 fifo_wr_data_o SHALL hold the pending word, and SHALL be 0 when nothing is pending.
REQ-026 stall_o SHALL equal pending && fifo_full_i.
REQ-027 If a word completes while pending is set and is not being written on that edge, the new word SHALL be dropped and overflow_o set; the remaining byte count still decrements.
REQ-028 If pending is written and a new word completes on the same edge, the new word SHALL load into pending without overflow.
REQ-029 RECV SHALL go to DRAIN on the edge that completes the final byte.
REQ-030 In DRAIN, when pending is 0 the FSM SHALL go to IDLE and done_o SHALL be high for exactly that one following cycle; busy_o is low in the same cycle.
REQ-031 The remaining-byte counter SHALL be 16 bits; the 65535-byte maximum SHALL not wrap.

Reset
REQ-032 On reset the FSM SHALL go to IDLE and pending, the shift register, the byte and sample counters, done_o and overflow_o SHALL clear; fifo_wr_en_o, stall_o and busy_o are therefore 0 and fifo_wr_data_o is 0.
REQ-033 Reset mid-transfer SHALL abort the transfer: no write and no done_o pulse follow it.

Structure
REQ-034 Lane-mode encodings and FSM state encodings SHALL live in the shared qspi package.
REQ-035 The block SHALL be a single module with no sub-modules; it connects directly to the fifo_rx write port.

Verification
REQ-036 x4, len 4, nibbles 1,2,3,4,5,6,7,8 on consecutive cycles 1-8 -> fifo_wr_en_o in cycle 9 with data 0x78563412, done_o in cycle 10.
REQ-037 x1, len 1, io_i[1] bits 1,0,1,0,0,1,0,1 -> one write of 0x000000A5, then done_o.
REQ-038 x2, len 6, bytes 0x01..0x06 -> writes 0x04030201 then 0x00000605, exactly 2 writes.
REQ-039 x4, len 12, fifo_full_i held high -> stall_o high after word 1; word 2 is dropped and overflow_o=1; releasing full yields the word-1 write, then done_o.
REQ-040 len 0 -> busy_o for one cycle, done_o, no write; also: reset asserted after 3 samples -> all outputs 0 and no later done_o.
